cart_loader: RTL and testbench

- Sits directly downstream of the HPS ioctl download interface and alongside the 2600 bank-switch detector.
- Buffers cartridge bytes from the ioctl stream into a small FIFO and writes them into cart memory over a req/ack write port.
- Throttles the HPS with ioctl_wait and tracks cart size.
- At end of download, latches the detector's force_bs/sc result and raises done once every byte has been committed to memory.

---
 rtl/cart_loader.sv | 190 +++++++++++++++++++
 tb/tb_cart_loader.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cart_loader.sv
// cart_loader: buffers HPS ioctl cartridge bytes in a small FIFO and commits them to cart memory.
// Define CART_LOADER_ZERO_FILL_EN to pad the image with 0x00 up to a power-of-two size before done.
module cart_loader #(
    parameter int ADDR_W     = 17,
    parameter int FIFO_DEPTH = 4,
    parameter int CART_INDEX = 1
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic [7:0]        ioctl_index,
    output logic              ioctl_wait,
    input  logic [3:0]        force_bs_in,
    input  logic              sc_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    output logic              mem_we,
    input  logic              mem_ack,
    output logic [31:0]       cart_size,
    output logic [3:0]        bs,
    output logic              sc,
    output logic              done,
    output logic              overflow
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // state | meaning
    // IDLE  | after reset, waiting for the first download
    // LOAD  | download window open, bytes accepted into the FIFO
    // DRAIN | window closed, FIFO still committing to memory
    // FILL  | zero padding up to the power-of-two image size
    // DONE  | cart fully in memory, bs/sc latched
    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, FILL, DONE} state_t;

    state_t               state;
    logic                 download_q;
    logic [ADDR_W+7:0]    fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [CNT_W-1:0]     count, count_next;
    logic                 dl_rise, dl_fall, accept, in_range, fifo_full, push, pop;
    logic                 unused_bits;

    assign unused_bits = ^ioctl_index[7:6];
    assign dl_rise     = ioctl_download & ~download_q;
    assign dl_fall     = ~ioctl_download & download_q;
    assign accept      = (state == LOAD) & ioctl_download & ioctl_wr
                       & (ioctl_index[5:0] == 6'(CART_INDEX));
    assign in_range    = (ioctl_addr[24:ADDR_W] == '0);
    assign fifo_full   = (count == CNT_W'(FIFO_DEPTH));
    assign push        = accept & in_range & ~fifo_full;
    assign pop         = mem_we & mem_ack & (state != FILL);
    assign rd_ptr_nxt  = rd_ptr + PTR_W'(1);

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + CNT_W'(1);
        else if (pop && !push)
            count_next = count - CNT_W'(1);
    end

`ifdef CART_LOADER_ZERO_FILL_EN
    logic [32:0] fill_addr, fill_next, fill_limit;

    assign fill_next = fill_addr + 33'd1;

    // Smallest power of two >= max(cart_size, 2048), capped at the memory size.
    always_comb begin
        fill_limit = 33'd1 << ADDR_W;
        for (int i = ADDR_W - 1; i >= 11; i--)
            if ({1'b0, cart_size} <= (33'd1 << i))
                fill_limit = 33'd1 << i;
    end
`endif

    always_ff @(posedge clk_sys) begin
        if (push)
            fifo_mem[wr_ptr] <= {ioctl_addr[ADDR_W-1:0], ioctl_dout};
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ioctl_wait <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr_nxt;
            count      <= count_next;
            // One slot of slack covers the HPS reacting a cycle late.
            ioctl_wait <= (count_next >= CNT_W'(FIFO_DEPTH - 1));
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            download_q <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
            cart_size  <= '0;
            bs         <= '0;
            sc         <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
`ifdef CART_LOADER_ZERO_FILL_EN
            fill_addr  <= '0;
`endif
        end else begin
            download_q <= ioctl_download;

            if (accept) begin
                cart_size <= {7'd0, ioctl_addr} + 32'd1;
                if (!in_range || fifo_full)
                    overflow <= 1'b1;
            end

            if (state != FILL) begin
                if (mem_we && mem_ack) begin
                    if (count > CNT_W'(1))
                        {mem_addr, mem_din} <= fifo_mem[rd_ptr_nxt];
                    else
                        mem_we <= 1'b0;
                end else if (!mem_we && count != '0) begin
                    {mem_addr, mem_din} <= fifo_mem[rd_ptr];
                    mem_we              <= 1'b1;
                end
            end

            case (state)
                IDLE, DONE: begin
                    if (dl_rise) begin
                        state     <= LOAD;
                        done      <= 1'b0;
                        overflow  <= 1'b0;
                        cart_size <= '0;
                    end
                end
                LOAD: begin
                    if (dl_fall)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (count == '0 && !mem_we) begin
`ifdef CART_LOADER_ZERO_FILL_EN
                        state     <= FILL;
                        fill_addr <= {1'b0, cart_size};
`else
                        state <= DONE;
                        bs    <= force_bs_in;
                        sc    <= sc_in;
                        done  <= 1'b1;
`endif
                    end
                end
`ifdef CART_LOADER_ZERO_FILL_EN
                FILL: begin
                    if (mem_we) begin
                        if (mem_ack) begin
                            fill_addr <= fill_next;
                            if (fill_next < fill_limit)
                                mem_addr <= ADDR_W'(fill_next);
                            else
                                mem_we <= 1'b0;
                        end
                    end else if (fill_addr < fill_limit) begin
                        mem_addr <= ADDR_W'(fill_addr);
                        mem_din  <= 8'h00;
                        mem_we   <= 1'b1;
                    end else begin
                        state <= DONE;
                        bs    <= force_bs_in;
                        sc    <= sc_in;
                        done  <= 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cart_loader.sv
// Self-checking bench for cart_loader: table-driven downloads, directed corner cases and
// randomized downloads scored against a queue of expected memory writes.
module tb_cart_loader;
    localparam int ADDR_W = 17;
    localparam int CAP    = 1 << ADDR_W;

    logic              clk_sys = 1'b0;
    logic              reset = 1'b1;
    logic              ioctl_download = 1'b0;
    logic              ioctl_wr = 1'b0;
    logic [24:0]       ioctl_addr = '0;
    logic [7:0]        ioctl_dout = '0;
    logic [7:0]        ioctl_index = '0;
    logic              ioctl_wait;
    logic [3:0]        force_bs_in = '0;
    logic              sc_in = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_din;
    logic              mem_we;
    logic              mem_ack = 1'b0;
    logic [31:0]       cart_size;
    logic [3:0]        bs;
    logic              sc, done, overflow;

    cart_loader #(.ADDR_W(ADDR_W), .FIFO_DEPTH(4), .CART_INDEX(1)) dut (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
        .ioctl_wait(ioctl_wait), .force_bs_in(force_bs_in), .sc_in(sc_in),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_ack(mem_ack),
        .cart_size(cart_size), .bs(bs), .sc(sc), .done(done), .overflow(overflow)
    );

    typedef struct { logic [16:0] addr; logic [7:0] data; } wr_t;

    typedef struct {
        logic [7:0]  idx;
        logic [24:0] a0;
        int          len;
        logic [3:0]  fbs;
        logic        fsc;
        bit          gaps;
        int          hold;
        bit          chk_lat;
        bit          rnd_ack;
        logic [31:0] exp_size;
        logic        exp_ov;
    } vec_t;

    int          checks = 0, failures = 0;
    int          hold_cnt = 0;
    bit          ack_rand = 1'b0;
    int          cyc = 0, last_ack_cyc = 0;
    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [7:0]  cur_idx = '0;
    logic [31:0] m_size = '0;
    bit          m_ov = 1'b0;
    logic        prev_we = 1'b0, prev_ack = 1'b0;
    logic [16:0] prev_addr = '0;
    logic [7:0]  prev_din = '0;
    vec_t        vecs[5];

    initial forever #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Memory ack source: held low for hold_cnt cycles, otherwise always 1 or random.
    initial forever begin
        @(posedge clk_sys);
        #2;
        if (hold_cnt > 0) begin
            mem_ack = 1'b0;
            hold_cnt--;
        end else begin
            mem_ack = ack_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Write monitor: a handshake is seen here, half a cycle before the edge that completes it.
    initial forever begin
        @(negedge clk_sys);
        cyc++;
        if (reset) begin
            prev_we  = 1'b0;
            prev_ack = 1'b0;
        end else begin
            if (prev_we && !prev_ack) begin
                check("we_held", 32'(mem_we), 32'd1);
                check("addr_stable", 32'(mem_addr), 32'(prev_addr));
                check("din_stable", 32'(mem_din), 32'(prev_din));
            end
            if (mem_we && mem_ack) begin
                last_ack_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_din);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
                    check("wr_data", 32'(mem_din), 32'(mon_e.data));
                end
            end
            prev_we   = mem_we;
            prev_ack  = mem_ack;
            prev_addr = mem_addr;
            prev_din  = mem_din;
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic start_dl(input logic [7:0] idx, input logic [3:0] fbs, input logic fsc);
        ioctl_index    = idx;
        force_bs_in    = fbs;
        sc_in          = fsc;
        ioctl_download = 1'b1;
        cur_idx        = idx;
        m_size         = '0;
        m_ov           = 1'b0;
        tick();
    endtask

    // Reference rules: matching index updates size; out-of-range or dropped bytes set overflow.
    task automatic model_byte(input logic [24:0] a, input logic [7:0] d, input bit stored);
        if (cur_idx[5:0] == 6'd1) begin
            m_size = 32'(a) + 32'd1;
            if (a >= 25'(CAP) || !stored)
                m_ov = 1'b1;
            else
                exp_q.push_back('{a[16:0], d});
        end
    endtask

    task automatic run_dl(input logic [7:0] idx, input logic [24:0] a0, input int len,
                          input logic [3:0] fbs, input logic fsc, input bit gaps, input int hold,
                          output int strobes_at_wait);
        int sent   = 0;
        int budget = 0;
        bit pw     = 1'b0;
        bit seen   = 1'b0;
        strobes_at_wait = -1;
        start_dl(idx, fbs, fsc);
        hold_cnt = hold;
        while (sent < len && budget < 20000) begin
            if (ioctl_wait && !seen) begin
                seen            = 1'b1;
                strobes_at_wait = sent;
            end
            // The HPS reacts to ioctl_wait one cycle late.
            if (!pw && (!gaps || $urandom_range(0, 2) != 0)) begin
                ioctl_wr   = 1'b1;
                ioctl_addr = a0 + 25'(sent);
                ioctl_dout = 8'($urandom);
                model_byte(ioctl_addr, ioctl_dout, 1'b1);
                sent++;
            end else begin
                ioctl_wr = 1'b0;
            end
            pw = ioctl_wait;
            tick();
            budget++;
        end
        ioctl_wr = 1'b0;
        check("strobes_sent", 32'(sent), 32'(len));
    endtask

    task automatic finish_dl(output logic [31:0] size_o, output logic ov_o, output logic [3:0] bs_o,
                             output logic sc_o, output int lat);
        int n = 0;
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
`ifdef CART_LOADER_ZERO_FILL_EN
        begin
            longint p = 2048;
            while (p < longint'(m_size) && p < CAP) p = p * 2;
            if (p > CAP) p = CAP;
            for (longint a = longint'(m_size); a < p; a++) exp_q.push_back('{17'(a), 8'h00});
        end
`endif
        while (!done && n < 20000) begin
            @(negedge clk_sys);
            n++;
        end
        check("done", 32'(done), 32'd1);
        lat = cyc - last_ack_cyc;
        check("all_writes_seen", 32'(exp_q.size()), 32'd0);
        check("wait_idle", 32'(ioctl_wait), 32'd0);
        check("we_idle", 32'(mem_we), 32'd0);
        size_o = cart_size;
        ov_o   = overflow;
        bs_o   = bs;
        sc_o   = sc;
        exp_q.delete();
        tick();
    endtask

    initial begin
        logic [31:0] r_size;
        logic        r_ov, r_sc;
        logic [3:0]  r_bs;
        int          lat, saw;
        logic [7:0]  idx_pool[4];
        logic [24:0] a0;

        vecs[0] = '{8'd1,  25'd0,       4096, 4'h2, 1'b0, 1'b0, 0,  1'b1, 1'b0, 32'h1000,  1'b0};
        vecs[1] = '{8'd0,  25'd0,       50,   4'h7, 1'b1, 1'b1, 0,  1'b0, 1'b1, 32'h0,     1'b0};
        vecs[2] = '{8'd1,  25'h1FFFE,   3,    4'h3, 1'b0, 1'b0, 0,  1'b0, 1'b1, 32'h20001, 1'b1};
        vecs[3] = '{8'h41, 25'd0,       3000, 4'h9, 1'b1, 1'b1, 0,  1'b0, 1'b1, 32'd3000,  1'b0};
        vecs[4] = '{8'd1,  25'h100,     20,   4'h5, 1'b0, 1'b0, 20, 1'b0, 1'b0, 32'h114,   1'b0};
        idx_pool = '{8'd1, 8'h41, 8'd0, 8'd9};

        repeat (3) tick();
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_wait", 32'(ioctl_wait), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_size", cart_size, 32'd0);
        check("rst_bs_sc", {27'd0, bs, sc}, 32'd0);
        check("rst_ov", 32'(overflow), 32'd0);
        check("rst_addr_din", {7'd0, mem_addr, mem_din}, 32'd0);
        reset = 1'b0;
        tick();
        check("idle_done", 32'(done), 32'd0);

        foreach (vecs[i]) begin
            ack_rand = vecs[i].rnd_ack;
            run_dl(vecs[i].idx, vecs[i].a0, vecs[i].len, vecs[i].fbs, vecs[i].fsc,
                   vecs[i].gaps, vecs[i].hold, saw);
            finish_dl(r_size, r_ov, r_bs, r_sc, lat);
            check($sformatf("vec%0d_size", i), r_size, vecs[i].exp_size);
            check($sformatf("vec%0d_ov", i), 32'(r_ov), 32'(vecs[i].exp_ov));
            check($sformatf("vec%0d_bs", i), 32'(r_bs), 32'(vecs[i].fbs));
            check($sformatf("vec%0d_sc", i), 32'(r_sc), 32'(vecs[i].fsc));
            if (vecs[i].chk_lat)
                check($sformatf("vec%0d_done_within_3", i), 32'(lat <= 3), 32'd1);
            if (vecs[i].hold > 0)
                check($sformatf("vec%0d_wait_at_3", i), 32'(saw), 32'd3);
        end

        // Full FIFO with acks held off: four bytes stored, the next two dropped.
        ack_rand = 1'b0;
        hold_cnt = 1000;
        start_dl(8'd1, 4'hA, 1'b0);
        hold_cnt = 1000;
        for (int i = 0; i < 6; i++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'(i);
            ioctl_dout = 8'($urandom);
            model_byte(ioctl_addr, ioctl_dout, i < 4);
            tick();
        end
        ioctl_wr = 1'b0;
        hold_cnt = 0;
        finish_dl(r_size, r_ov, r_bs, r_sc, lat);
        check("full_size", r_size, 32'd6);
        check("full_ov", 32'(r_ov), 32'd1);

        // Reset with two entries pending and a write stalled in flight.
        hold_cnt = 1000;
        start_dl(8'd1, 4'hB, 1'b1);
        hold_cnt = 1000;
        for (int i = 0; i < 2; i++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'(8 + i);
            ioctl_dout = 8'($urandom);
            tick();
        end
        ioctl_wr = 1'b0;
        tick();
        check("pre_rst_we", 32'(mem_we), 32'd1);
        reset          = 1'b1;
        ioctl_download = 1'b0;
        #1;
        check("mid_rst_we", 32'(mem_we), 32'd0);
        check("mid_rst_wait", 32'(ioctl_wait), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_size", cart_size, 32'd0);
        exp_q.delete();
        hold_cnt = 0;
        tick();
        reset = 1'b0;
        tick();
        run_dl(8'd1, 25'h40, 30, 4'hC, 1'b0, 1'b1, 0, saw);
        finish_dl(r_size, r_ov, r_bs, r_sc, lat);
        check("post_rst_size", r_size, 32'h5E);
        check("post_rst_ov", 32'(r_ov), 32'd0);
        check("post_rst_bs", 32'(r_bs), 32'hC);

        // Randomized downloads scored against the reference rules.
        ack_rand = 1'b1;
        for (int k = 0; k < 8; k++) begin
            logic [7:0] idx;
            logic [3:0] fbs;
            logic       fsc;
            int         len;
            idx = idx_pool[$urandom_range(0, 3)];
            fbs = 4'($urandom);
            fsc = 1'($urandom);
            len = $urandom_range(1, 150);
            if ($urandom_range(0, 3) == 0)
                a0 = 25'(CAP - $urandom_range(1, 40));
            else
                a0 = 25'($urandom_range(0, 32'h1F000));
            run_dl(idx, a0, len, fbs, fsc, 1'b1, 0, saw);
            finish_dl(r_size, r_ov, r_bs, r_sc, lat);
            check($sformatf("rnd%0d_size", k), r_size, m_size);
            check($sformatf("rnd%0d_ov", k), 32'(r_ov), 32'(m_ov));
            check($sformatf("rnd%0d_bs", k), 32'(r_bs), 32'(fbs));
            check($sformatf("rnd%0d_sc", k), 32'(r_sc), 32'(fsc));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
